muldiv_seq: RTL and testbench

Iterative RV32M multiply/divide unit with its sequencing controller, sitting in the execute stage beside the ALU. It accepts the 4-bit `mulDiv_op` code produced by the instruction decoder, runs a radix-2 shift-add multiply or restoring divide over 32 iteration cycles, and holds the pipeline with `busy` until the result is ready. A pipeline flush (`kill`) aborts an operation in flight.

---
 rtl/muldiv_seq.sv | 181 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// single-cycle fast path for divide-by-zero and signed overflow, flushable by kill.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      mulDiv_op,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    // state  | meaning
    // S_IDLE | waiting for an accepted instruction
    // S_CALC | one multiply/divide step per cycle, counter counts down to 0
    // S_FIX  | sign correction and result select, result registered
    // S_DONE | result_valid pulse, pipeline advances

    localparam int CW = $clog2(XLEN);

    localparam logic [3:0] OP_MUL    = 4'b0011;
    localparam logic [3:0] OP_MULH   = 4'b0101;
    localparam logic [3:0] OP_MULHU  = 4'b0111;
    localparam logic [3:0] OP_MULHSU = 4'b0110;
    localparam logic [3:0] OP_DIV    = 4'b1001;
    localparam logic [3:0] OP_DIVU   = 4'b1011;
    localparam logic [3:0] OP_REM    = 4'b1101;
    localparam logic [3:0] OP_REMU   = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t state, state_next;

    logic [3:0]        op_q;
    logic              sign_a_q, sign_b_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opnd;

    logic              legal, signed_a, signed_b, is_div, is_rem;
    logic              sign_a, sign_b, special, div_zero, div_ovf;
    logic              accept;
    logic [XLEN-1:0]   mag_a, mag_b, fast_result;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sr;
    logic [XLEN-1:0]   div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] step_next;

    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quot, rem_v, fix_result;

    always_comb begin
        legal    = 1'b0;
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (mulDiv_op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                legal    = 1'b1;
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            OP_MULHSU: begin
                legal    = 1'b1;
                signed_a = 1'b1;
            end
            OP_MULHU, OP_DIVU, OP_REMU: legal = 1'b1;
            default: ;
        endcase
    end

    // Every legal divide/remainder code has bit 3 set; bit 2 separates remainder.
    assign is_div = mulDiv_op[3];
    assign is_rem = mulDiv_op[2];

    assign sign_a = signed_a & op_a[XLEN-1];
    assign sign_b = signed_b & op_b[XLEN-1];
    assign mag_a  = sign_a ? -op_a : op_a;
    assign mag_b  = sign_b ? -op_b : op_b;

    assign div_zero = (op_b == '0);
    assign div_ovf  = signed_a & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    assign special  = is_div & (div_zero | div_ovf);

    always_comb begin
        if (div_zero) fast_result = is_rem ? op_a : '1;
        else          fast_result = is_rem ? '0 : op_a;
    end

    assign accept = start & (state == S_IDLE) & legal & ~kill;
    assign busy   = accept | (state == S_CALC) | (state == S_FIX);

    // Multiply keeps the carry of the upper-half add; divide shares acc as {rem, quot}.
    assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opnd};
    assign div_sr   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_ge   = (div_sr >= {1'b0, opnd});
    assign div_diff = div_sr[XLEN-1:0] - opnd;

    always_comb begin
        if (op_q[3]) begin
            if (div_ge) step_next = {div_diff, acc[XLEN-2:0], 1'b1};
            else        step_next = {div_sr[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end else begin
            if (acc[0]) step_next = {mul_sum, acc[XLEN-1:1]};
            else        step_next = {1'b0, acc[2*XLEN-1:1]};
        end
    end

    assign prod  = (sign_a_q ^ sign_b_q) ? -acc : acc;
    assign quot  = (sign_a_q ^ sign_b_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem_v = sign_a_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

    always_comb begin
        case (op_q)
            OP_MUL:                        fix_result = prod[XLEN-1:0];
            OP_MULH, OP_MULHU, OP_MULHSU:  fix_result = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_result = quot;
            default:                       fix_result = rem_v;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (kill) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (accept) state_next = special ? S_DONE : S_CALC;
                S_CALC: if (cnt == '0) state_next = S_FIX;
                S_FIX:  state_next = S_DONE;
                S_DONE: state_next = S_IDLE;
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q         <= '0;
            sign_a_q     <= 1'b0;
            sign_b_q     <= 1'b0;
            cnt          <= '0;
            acc          <= '0;
            opnd         <= '0;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= (state_next == S_DONE);
            if (accept) begin
                op_q     <= mulDiv_op;
                sign_a_q <= sign_a;
                sign_b_q <= sign_b;
                cnt      <= CW'(XLEN-1);
                if (is_div) begin
                    opnd <= mag_b;
                    acc  <= {{XLEN{1'b0}}, mag_a};
                end else begin
                    opnd <= mag_a;
                    acc  <= {{XLEN{1'b0}}, mag_b};
                end
                if (special) result <= fast_result;
            end else if (state == S_CALC) begin
                acc <= step_next;
                cnt <= cnt - CW'(1);
            end
            if ((state == S_FIX) && !kill) result <= fix_result;
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed vector table, randomized ops against an
// arithmetic reference model, and hand-written kill / reset / back-to-back / illegal sequences.
module tb_muldiv_seq;

    localparam logic [3:0] OP_MUL    = 4'b0011;
    localparam logic [3:0] OP_MULH   = 4'b0101;
    localparam logic [3:0] OP_MULHU  = 4'b0111;
    localparam logic [3:0] OP_MULHSU = 4'b0110;
    localparam logic [3:0] OP_DIV    = 4'b1001;
    localparam logic [3:0] OP_DIVU   = 4'b1011;
    localparam logic [3:0] OP_REM    = 4'b1101;
    localparam logic [3:0] OP_REMU   = 4'b1111;

    logic        clk = 1'b0;
    logic        rst, start, kill;
    logic [3:0]  mulDiv_op;
    logic [31:0] op_a, op_b;
    logic        busy, result_valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expv;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mulDiv_op    (mulDiv_op),
        .op_a         (op_a),
        .op_b         (op_b),
        .kill         (kill),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, got, expv);
        end
    endtask

    // Reference: 64-bit products of sign/zero-extended operands, native signed division.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] sa, sb, ua, ub, p;
        logic signed [31:0] q;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            OP_MUL:    begin p = sa * sb; return p[31:0];  end
            OP_MULH:   begin p = sa * sb; return p[63:32]; end
            OP_MULHU:  begin p = ua * ub; return p[63:32]; end
            OP_MULHSU: begin p = sa * ub; return p[63:32]; end
            OP_DIV: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = $signed(a) / $signed(b);
                return q;
            end
            OP_REM: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                q = $signed(a) % $signed(b);
                return q;
            end
            OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            OP_REMU: return (b == 0) ? a : a % b;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit is_fast(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op != OP_DIV && op != OP_DIVU && op != OP_REM && op != OP_REMU) return 1'b0;
        if (b == 0) return 1'b1;
        return (op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    task automatic add_vec(input string n, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] e);
        vec_t v;
        v.name = n; v.op = op; v.a = a; v.b = b; v.expv = e;
        vecs.push_back(v);
    endtask

    // Called at a negedge: presents the instruction for cycle t.
    task automatic drive_start(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               output bit busy_t, output logic [31:0] r0);
        start = 1'b1; mulDiv_op = op; op_a = a; op_b = b;
        #1;
        busy_t = busy;
        r0     = result;
    endtask

    task automatic finish_op(input string name, input logic [31:0] expv, input int exp_lat,
                             input int exp_busy, input bit busy_t, input logic [31:0] r0);
        int lat = 0;
        int nbusy;
        bit held = 1'b1;
        logic [31:0] got = '0;
        nbusy = busy_t ? 1 : 0;
        @(posedge clk);
        #1;
        start = 1'b0; mulDiv_op = 4'b0000; op_a = $urandom; op_b = $urandom;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (busy) nbusy++;
            if (result_valid) begin
                lat = c;
                got = result;
                break;
            end
            if (result !== r0) held = 1'b0;
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_busy_cycles"}, nbusy, exp_busy);
        chk({name, "_result"}, got, expv);
        chk({name, "_result_held"}, held, 1'b1);
        @(negedge clk);
        chk({name, "_valid_pulse"}, result_valid, 1'b0);
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expv);
        bit bt;
        logic [31:0] r0;
        int el;
        @(negedge clk);
        drive_start(op, a, b, bt, r0);
        el = is_fast(op, a, b) ? 1 : 34;
        finish_op(name, expv, el, el, bt, r0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops [8];
        logic [3:0]  op;
        logic [31:0] a, b, r0;
        bit          bt;
        int          nv, p1, p2;

        ops = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};

        rst = 1'b1; start = 1'b0; kill = 1'b0; mulDiv_op = 4'b0000; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_valid", result_valid, 1'b0);
        chk("reset_result", result, 32'h0);
        rst = 1'b0;

        add_vec("mul_7_m3",      OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        add_vec("mulh_m1_m1",    OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000);
        add_vec("mulhu_m1_m1",   OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        add_vec("mulhsu_m1_m1",  OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        add_vec("mulhu_min_2",   OP_MULHU,  32'h8000_0000,  32'd2,         32'h0000_0001);
        add_vec("div_m7_2",      OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        add_vec("rem_m7_2",      OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        add_vec("div_7_m2",      OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD);
        add_vec("rem_7_m2",      OP_REM,    32'd7,          32'hFFFF_FFFE, 32'h0000_0001);
        add_vec("divu_100_7",    OP_DIVU,   32'd100,        32'd7,         32'd14);
        add_vec("remu_100_7",    OP_REMU,   32'd100,        32'd7,         32'd2);
        add_vec("div_x_0",       OP_DIV,    32'd12345,      32'd0,         32'hFFFF_FFFF);
        add_vec("divu_x_0",      OP_DIVU,   32'd7,          32'd0,         32'hFFFF_FFFF);
        add_vec("rem_x_0",       OP_REM,    32'hFFFF_FFF0,  32'd0,         32'hFFFF_FFF0);
        add_vec("remu_5_0",      OP_REMU,   32'd5,          32'd0,         32'd5);
        add_vec("div_ovf",       OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        add_vec("rem_ovf",       OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);

        foreach (vecs[i]) run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expv);

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 7)];
            a  = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'h0;
                1:       b = $urandom_range(1, 20);
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            run_op("rand", op, a, b, model(op, a, b));
        end

        // kill a divide at t+10, then accept a multiply at t+11
        run_op("pre_kill", OP_MUL, 32'd3, 32'd5, 32'd15);
        @(negedge clk);
        drive_start(OP_DIV, 32'd100, 32'd7, bt, r0);
        @(posedge clk);
        #1 start = 1'b0;
        nv = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (result_valid) nv++;
        end
        chk("kill_busy_before", busy, 1'b1);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_idle_busy", busy, 1'b0);
        chk("kill_no_valid", nv + int'(result_valid), 0);
        chk("kill_result_kept", result, 32'd15);
        drive_start(OP_MUL, 32'd9, 32'hFFFF_FFF7, bt, r0);
        finish_op("post_kill_mul", 32'hFFFF_FFAF, 34, 34, bt, r0);

        // start held high: DONE ignores it, next accept one cycle later
        @(negedge clk);
        start = 1'b1; mulDiv_op = OP_MUL; op_a = 32'd3; op_b = 32'd4;
        p1 = 0; p2 = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (result_valid) begin
                if (p1 == 0) p1 = c;
                else begin
                    p2 = c;
                    break;
                end
            end
        end
        start = 1'b0; mulDiv_op = 4'b0000;
        chk("b2b_first_valid", p1, 34);
        chk("b2b_second_valid", p2, 69);
        chk("b2b_result", result, 32'd12);
        repeat (36) @(negedge clk);

        // illegal codes never accept
        start = 1'b1; mulDiv_op = 4'b0100; op_a = $urandom; op_b = $urandom;
        #1 chk("illegal_0100_busy", busy, 1'b0);
        @(negedge clk);
        chk("illegal_0100_valid", result_valid, 1'b0);
        mulDiv_op = 4'b0000;
        #1 chk("illegal_0000_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        chk("illegal_0000_valid", result_valid, 1'b0);
        chk("illegal_result_kept", result, 32'd12);
        start = 1'b0;

        // reset at t+5 of a multiply
        @(negedge clk);
        drive_start(OP_MUL, 32'd6, 32'd7, bt, r0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_valid", result_valid, 1'b0);
        chk("rst_mid_result", result, 32'h0);
        nv = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (result_valid || busy) nv++;
        end
        chk("rst_mid_no_activity", nv, 0);

        run_op("post_rst_divu", OP_DIVU, 32'd1000, 32'd33, 32'd30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
